instr_fetch: RTL and testbench

- Fetch-side initiator for the 16-bit instruction ROM.
- Drives the ROM's 32-bit address and captures the combinational 16-bit instruction returned in the same cycle.
- Buffers fetched instructions in a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- Handles branch redirects (flush plus new PC) and out-of-range fetch faults.

---
 rtl/ifetch_pkg.sv | 22 ++
 rtl/ifetch_fifo.sv | 74 +++++++
 rtl/instr_fetch.sv | 124 ++++++++++++
 tb/tb_instr_fetch.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and default sizes for the instruction fetch unit.
//   ifetch_state_t  - fetch FSM state (IDLE / FETCH / FAULT)
//   ifetch_entry_t  - prefetch FIFO entry: fetch PC plus the 16-bit instruction
//   IFETCH_MEM_SIZE - default ROM depth in halfwords
//   IFETCH_DEPTH    - default prefetch FIFO depth
package ifetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FAULT = 2'd2
   } ifetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [15:0] instr;
   } ifetch_entry_t;

   localparam int unsigned IFETCH_MEM_SIZE = 1024;
   localparam int unsigned IFETCH_DEPTH    = 4;

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous prefetch FIFO of ifetch_entry_t.
//   clk_i, reset_i  - clock, synchronous active-high reset
//   push_i, wdata_i - enqueue; accepted when not full, or when full with a pop in the same cycle
//   pop_i, rdata_o  - dequeue; rdata_o is the current head
//   flush_i         - empties the FIFO; overrides push and pop
//   count_o, full_o, empty_o - occupancy status
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int unsigned DEPTH = IFETCH_DEPTH,
   localparam int unsigned PtrW = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          push_i,
   input  ifetch_entry_t wdata_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output ifetch_entry_t rdata_o,
   output logic [PtrW:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   ifetch_entry_t mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]   count_q, count_d;
   logic            do_push, do_pop;

   assign full_o  = (count_q == (PtrW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // When full, the write slot equals the head slot; the head is read out before the edge.
   assign do_push = push_i && (!full_o || pop_i) && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   always_comb begin
      count_d = count_q;
      if (flush_i) begin
         count_d = '0;
      end else begin
         unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PtrW+1)'(1);
            2'b01:   count_d = count_q - (PtrW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
      end
   end

   // Storage needs no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch-side initiator for a 16-bit instruction ROM with a prefetch FIFO.
//   clk, reset                 - clock, synchronous active-high reset
//   fetch_en                   - level enable for fetching
//   imem_addr / imem_instr     - ROM halfword address (registered PC) / combinational read data
//   instr, instr_pc            - FIFO head instruction and its PC
//   instr_valid / instr_ready  - decode handshake; pop when both high
//   redirect_valid/redirect_pc - taken branch: flush FIFO and restart at redirect_pc
//   fault                      - high while the FSM sits in FAULT (PC ran past the ROM)
// Optional macro IFETCH_PERF_EN adds saturating counters stall_cycles and fetch_count.
module instr_fetch
   import ifetch_pkg::*;
#(
   parameter int unsigned MEM_SIZE = IFETCH_MEM_SIZE,
   parameter int unsigned DEPTH    = IFETCH_DEPTH,
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_en,
   output logic [31:0] imem_addr,
   input  logic [15:0] imem_instr,
   output logic [15:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fault
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] fetch_count
`endif
);

   localparam int unsigned PtrW     = $clog2(DEPTH);
   localparam logic [31:0] MemSizeW = 32'(MEM_SIZE);

   ifetch_state_t state_q;
   logic [31:0]   pc_q;

   ifetch_entry_t fifo_wdata, fifo_rdata;
   logic [PtrW:0] fifo_count;
   logic          fifo_full, fifo_empty;
   logic          pop, push, push_ok, pc_oor, fetching, stall;

   assign pop      = instr_ready && (fifo_count != '0);
   assign push_ok  = !fifo_full || pop;
   assign pc_oor   = (pc_q >= MemSizeW);
   // Redirect suppresses any push in its cycle.
   assign fetching = (state_q == FETCH) && fetch_en && !pc_oor && !redirect_valid;
   assign push     = fetching && push_ok;
   assign stall    = fetching && !push_ok;

   assign fifo_wdata = '{pc: pc_q, instr: imem_instr};

   ifetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .reset_i (reset),
      .push_i  (push),
      .wdata_i (fifo_wdata),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign imem_addr   = pc_q;
   assign instr       = fifo_rdata.instr;
   assign instr_pc    = fifo_rdata.pc;
   assign instr_valid = !fifo_empty;
   assign fault       = (state_q == FAULT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
      end else if (redirect_valid) begin
         pc_q    <= redirect_pc;
         state_q <= fetch_en ? FETCH : IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (fetch_en) state_q <= FETCH;
            end
            FETCH: begin
               if (!fetch_en) begin
                  state_q <= IDLE;
               end else if (pc_oor) begin
                  state_q <= FAULT;
               end else if (push_ok) begin
                  pc_q <= pc_q + 32'd1;
               end
            end
            FAULT: begin
               state_q <= FAULT;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef IFETCH_PERF_EN
   logic [31:0] stall_cycles_q, fetch_count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_q <= '0;
         fetch_count_q  <= '0;
      end else begin
         if (stall && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
         if (push && (fetch_count_q != '1))   fetch_count_q  <= fetch_count_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign fetch_count  = fetch_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
   import ifetch_pkg::*;

   logic        clk = 1'b0;
   logic        reset, fetch_en, instr_ready, redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr, instr_pc;
   logic [15:0] imem_instr, instr;
   logic        instr_valid, fault;
`ifdef IFETCH_PERF_EN
   logic [31:0] stall_cycles, fetch_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // ROM model: mem[i] = i + 16'h100 inside the ROM.
   assign imem_instr = (imem_addr < 32'd1024) ? (16'h100 + imem_addr[15:0]) : 16'hDEAD;

   instr_fetch #(
      .MEM_SIZE (1024),
      .DEPTH    (4),
      .RESET_PC (32'd0)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_en       (fetch_en),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fault          (fault)
`ifdef IFETCH_PERF_EN
      ,
      .stall_cycles   (stall_cycles),
      .fetch_count    (fetch_count)
`endif
   );

   // One row per cycle: inputs driven this cycle, outputs expected this cycle (before the edge).
   typedef struct {
      logic        rst, en, rdy, rv;
      logic [31:0] rpc;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] ea;
      logic        ef;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic rst, en, rdy, rv, input logic [31:0] rpc,
                               input logic ev, input logic [31:0] epc, input logic [31:0] ea,
                               input logic ef);
      vec_t v;
      v.rst = rst; v.en = en; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
      v.ev = ev; v.epc = epc; v.ea = ea; v.ef = ef;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input int row, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      tick; tick;
      reset = 1'b0;
      #1;
      chk("reset_valid", -1, 32'(instr_valid), 32'd0);
      chk("reset_fault", -1, 32'(fault), 32'd0);
      chk("reset_addr", -1, imem_addr, 32'd0);

      // Straight-line fetch: first valid two cycles after fetch_en.
      add(0,1,1,0,0,   0,0,0,0);
      add(0,1,1,0,0,   0,0,0,0);
      add(0,1,1,0,0,   1,0,1,0);
      add(0,1,1,0,0,   1,1,2,0);
      add(0,1,1,0,0,   1,2,3,0);
      add(1,0,1,0,0,   1,3,4,0);
      // Backpressure: fill to 4, addr frozen at 4, head pc 0; then drain 0..7 in order.
      add(0,1,0,0,0,   0,0,0,0);
      add(0,1,0,0,0,   0,0,0,0);
      add(0,1,0,0,0,   1,0,1,0);
      add(0,1,0,0,0,   1,0,2,0);
      add(0,1,0,0,0,   1,0,3,0);
      for (int i = 0; i < 6; i++) add(0,1,0,0,0, 1,0,4,0);
      add(0,1,1,0,0,   1,0,4,0);
      for (int i = 1; i < 8; i++) add(0,1,1,0,0, 1,32'(i),32'(i+4),0);
      add(1,1,1,0,0,   1,8,12,0);
      // Redirect to 200 with three entries buffered.
      add(0,1,0,0,0,   0,0,0,0);
      add(0,1,0,0,0,   0,0,0,0);
      add(0,1,0,0,0,   1,0,1,0);
      add(0,1,0,0,0,   1,0,2,0);
      add(0,1,1,1,200, 1,0,3,0);
      add(0,1,1,0,0,   0,0,200,0);
      add(0,1,1,0,0,   1,200,201,0);
      add(0,1,1,0,0,   1,201,202,0);
      // Fault: run off the end of the ROM, then recover with a redirect to 5.
      add(0,1,1,1,1022, 1,202,203,0);
      add(0,1,1,0,0,   0,0,1022,0);
      add(0,1,1,0,0,   1,1022,1023,0);
      add(0,1,1,0,0,   1,1023,1024,0);
      add(0,1,1,0,0,   0,0,1024,1);
      add(0,1,1,1,5,   0,0,1024,1);
      add(0,1,1,0,0,   0,0,5,0);
      // Fill while stalled, then reset mid-stream.
      add(0,1,0,0,0,   1,5,6,0);
      add(0,1,0,0,0,   1,5,7,0);
      add(0,1,0,0,0,   1,5,8,0);
      add(1,1,0,0,0,   1,5,9,0);
      add(0,0,0,0,0,   0,0,0,0);
      add(0,0,0,0,0,   0,0,0,0);
      add(0,1,1,0,0,   0,0,0,0);
      add(0,1,1,0,0,   0,0,0,0);
      add(0,1,1,0,0,   1,0,1,0);

      foreach (vecs[r]) begin
         reset          = vecs[r].rst;
         fetch_en       = vecs[r].en;
         instr_ready    = vecs[r].rdy;
         redirect_valid = vecs[r].rv;
         redirect_pc    = vecs[r].rpc;
         #1;
         chk("valid", r, 32'(instr_valid), 32'(vecs[r].ev));
         chk("imem_addr", r, imem_addr, vecs[r].ea);
         chk("fault", r, 32'(fault), 32'(vecs[r].ef));
         if (vecs[r].ev) begin
            chk("instr_pc", r, instr_pc, vecs[r].epc);
            chk("instr", r, 32'(instr), 32'(16'h100 + vecs[r].epc[15:0]));
         end
         tick;
      end
      reset = 1'b0; redirect_valid = 1'b0;

`ifdef IFETCH_PERF_EN
      reset = 1'b1; tick;
      reset = 1'b0; fetch_en = 1'b1; instr_ready = 1'b0;
      repeat (5) tick;
      repeat (20) tick;
      chk("stall_cycles", 100, stall_cycles, 32'd20);
      chk("fetch_count", 100, fetch_count, 32'd4);
      instr_ready = 1'b1;
      repeat (5) tick;
      chk("fetch_count", 101, fetch_count, 32'd9);
      chk("stall_cycles", 101, stall_cycles, 32'd20);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
